iir_filter_mc: RTL



---
 rtl/iir_filter_mc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/iir_filter_mc.sv
// N-channel biquad IIR filter that steps one shared signed multiplier across all taps and channels.
// Optional IIR_FILTER_MC_BYPASS_EN adds a per-frame bypass input that passes the frame through and leaves the filter state untouched.
module iir_filter_mc #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int COEF_W   = 24,
    parameter int GUARD_W  = 8,
    parameter logic signed [COEF_W-1:0] B0 = 24'sh100000,
    parameter logic signed [COEF_W-1:0] B1 = '0,
    parameter logic signed [COEF_W-1:0] B2 = '0,
    parameter logic signed [COEF_W-1:0] A1 = '0,
    parameter logic signed [COEF_W-1:0] A2 = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
`ifdef IIR_FILTER_MC_BYPASS_EN
    input  logic                         bypass,
`endif
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   out_data
);

    localparam int Y_W    = DATA_W + GUARD_W;
    localparam int PROD_W = Y_W + COEF_W;
    localparam int ACC_W  = Y_W + COEF_W + 3;
    localparam int FRAC_W = COEF_W - 4;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_UPDATE, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [2:0]                  tap_q, tap_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic [CHANNELS*DATA_W-1:0]  frame_q, frame_d;
    logic [CHANNELS*DATA_W-1:0]  res_q, res_d;
    logic [CHANNELS*DATA_W-1:0]  out_data_q, out_data_d;
    logic                        bypass_q, bypass_d;
    logic signed [DATA_W-1:0]    x1_q [CHANNELS];
    logic signed [DATA_W-1:0]    x1_d [CHANNELS];
    logic signed [DATA_W-1:0]    x2_q [CHANNELS];
    logic signed [DATA_W-1:0]    x2_d [CHANNELS];
    logic signed [Y_W-1:0]       y1_q [CHANNELS];
    logic signed [Y_W-1:0]       y1_d [CHANNELS];
    logic signed [Y_W-1:0]       y2_q [CHANNELS];
    logic signed [Y_W-1:0]       y2_d [CHANNELS];

    logic                        bypass_in;
    logic                        last_ch;
    int                          ch_idx;
    logic signed [DATA_W-1:0]    x0;
    logic signed [Y_W-1:0]       op;
    logic signed [COEF_W-1:0]    coef;
    logic signed [PROD_W-1:0]    op_w, coef_w, prod;
    logic signed [ACC_W-1:0]     prod_ext;
    logic signed [ACC_W-1:0]     y_full;
    logic signed [DATA_W-1:0]    y_out;

`ifdef IIR_FILTER_MC_BYPASS_EN
    assign bypass_in = bypass;
`else
    assign bypass_in = 1'b0;
`endif

    assign last_ch = (ch_q == CH_W'(CHANNELS - 1));
    assign ch_idx  = int'(ch_q);

    function automatic logic signed [Y_W-1:0] sat_y(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-Y_W:0] hi;
        hi = v[ACC_W-1:Y_W-1];
        if (&hi || ~|hi) return v[Y_W-1:0];
        return v[ACC_W-1] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] hi;
        hi = v[ACC_W-1:DATA_W-1];
        if (&hi || ~|hi) return v[DATA_W-1:0];
        return v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_MAC;
            S_MAC:    if (tap_q == 3'd4) state_d = S_UPDATE;
            S_UPDATE: state_d = last_ch ? S_DONE : S_MAC;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // Shared multiplier: the tap index selects which state word meets which coefficient.
    always_comb begin
        x0 = $signed(frame_q[ch_idx*DATA_W +: DATA_W]);
        case (tap_q)
            3'd0:    begin op = {{GUARD_W{x0[DATA_W-1]}}, x0}; coef = B0; end
            3'd1:    begin op = {{GUARD_W{x1_q[ch_idx][DATA_W-1]}}, x1_q[ch_idx]}; coef = B1; end
            3'd2:    begin op = {{GUARD_W{x2_q[ch_idx][DATA_W-1]}}, x2_q[ch_idx]}; coef = B2; end
            3'd3:    begin op = y1_q[ch_idx]; coef = A1; end
            default: begin op = y2_q[ch_idx]; coef = A2; end
        endcase
        op_w     = {{COEF_W{op[Y_W-1]}}, op};
        coef_w   = {{Y_W{coef[COEF_W-1]}}, coef};
        prod     = op_w * coef_w;
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        y_full   = acc_q >>> FRAC_W;
        y_out    = bypass_q ? x0 : sat_out(y_full);
    end

    always_comb begin
        ch_d       = ch_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        frame_d    = frame_q;
        res_d      = res_q;
        out_data_d = out_data_q;
        bypass_d   = bypass_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    frame_d  = in_data;
                    bypass_d = bypass_in;
                    ch_d     = '0;
                    tap_d    = '0;
                end
            end
            S_MAC: begin
                tap_d = tap_q + 3'd1;
                if (tap_q == 3'd0)      acc_d = prod_ext;
                else if (tap_q >= 3'd3) acc_d = acc_q - prod_ext;
                else                    acc_d = acc_q + prod_ext;
            end
            S_UPDATE: begin
                tap_d = '0;
                res_d[ch_idx*DATA_W +: DATA_W] = y_out;
                if (!bypass_q) begin
                    x2_d[ch_idx] = x1_q[ch_idx];
                    x1_d[ch_idx] = x0;
                    y2_d[ch_idx] = y1_q[ch_idx];
                    y1_d[ch_idx] = sat_y(y_full);
                end
                if (last_ch) begin
                    out_data_d = res_d;
                    ch_d       = '0;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q       <= '0;
            tap_q      <= '0;
            acc_q      <= '0;
            frame_q    <= '0;
            res_q      <= '0;
            out_data_q <= '0;
            bypass_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            ch_q       <= ch_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            frame_q    <= frame_d;
            res_q      <= res_d;
            out_data_q <= out_data_d;
            bypass_q   <= bypass_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
        end
    end

    assign out_data = out_data_q;

endmodule
